// File: rtl/alarm_clock_pkg.sv
// -----------------------------------------------------------------------------
// alarm_clock_pkg
// Shared definitions for the alarm clock mode controller:
//   - mode_e      : 3-bit set-mode state encoding (RUN, SET_T_HR, SET_T_MIN,
//                   SET_A_HR, SET_A_MIN)
//   - *_DEF       : default values for the controller parameters
//   - helpers     : mode sequencing and state classification functions
// -----------------------------------------------------------------------------
package alarm_clock_pkg;

   typedef enum logic [2:0] {
      MODE_RUN       = 3'd0,
      MODE_SET_T_HR  = 3'd1,
      MODE_SET_T_MIN = 3'd2,
      MODE_SET_A_HR  = 3'd3,
      MODE_SET_A_MIN = 3'd4
   } mode_e;

   localparam int TIMEOUT_S_DEF     = 10;
   localparam int REPEAT_DELAY_DEF  = 4;
   localparam int REPEAT_PERIOD_DEF = 1;
   localparam int BLINK_DIV_DEF     = 2;

   // Mode button sequence: RUN -> T_HR -> T_MIN -> A_HR -> A_MIN -> RUN.
   function automatic mode_e next_mode(input mode_e m);
      mode_e n;
      case (m)
         MODE_RUN:       n = MODE_SET_T_HR;
         MODE_SET_T_HR:  n = MODE_SET_T_MIN;
         MODE_SET_T_MIN: n = MODE_SET_A_HR;
         MODE_SET_A_HR:  n = MODE_SET_A_MIN;
         default:        n = MODE_RUN;
      endcase
      return n;
   endfunction

   function automatic logic is_set_state(input mode_e m);
      return m != MODE_RUN;
   endfunction

   function automatic logic is_hr_state(input mode_e m);
      return (m == MODE_SET_T_HR) || (m == MODE_SET_A_HR);
   endfunction

   function automatic logic is_min_state(input mode_e m);
      return (m == MODE_SET_T_MIN) || (m == MODE_SET_A_MIN);
   endfunction

   function automatic logic is_time_state(input mode_e m);
      return (m == MODE_SET_T_HR) || (m == MODE_SET_T_MIN);
   endfunction

   function automatic logic is_alarm_state(input mode_e m);
      return (m == MODE_SET_A_HR) || (m == MODE_SET_A_MIN);
   endfunction

endpackage

// File: rtl/btn_edge_repeat.sv
// -----------------------------------------------------------------------------
// btn_edge_repeat
// Rising-edge detector with hold-to-repeat for one debounced button level.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   level      : debounced, synchronized button level (1 = pressed)
//   tick       : one-cycle strobe that paces the auto-repeat
//   press      : combinational, high in the cycle the level first reads 1
//   rep        : combinational, high in the tick cycle that completes the
//                REPEAT_DELAY (first) or REPEAT_PERIOD (later) hold interval
// Both outputs are meant to be registered by the consumer.
// -----------------------------------------------------------------------------
module btn_edge_repeat
   import alarm_clock_pkg::*;
#(
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   input  logic tick,
   output logic press,
   output logic rep
);

   localparam logic [3:0] LP_DELAY  = 4'(REPEAT_DELAY);
   localparam logic [3:0] LP_PERIOD = 4'(REPEAT_PERIOD);

   logic       r_prev;
   logic       r_repeating;   // first repeat already issued; now pacing by PERIOD
   logic [3:0] r_cnt;

   logic [3:0] w_cnt_inc;
   logic [3:0] w_limit;

   // NOTE: every signal driven here gets a value on every path, so no latch
   // is inferred.
   always_comb begin
      w_cnt_inc = r_cnt + 4'd1;
      w_limit   = r_repeating ? LP_PERIOD : LP_DELAY;
      press     = level & ~r_prev;
      // Ticks count only while held past the press cycle.
      rep       = level & r_prev & tick & (w_cnt_inc == w_limit);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev      <= 1'b0;
         r_repeating <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_prev <= level;
         if (!level || press) begin
            r_cnt       <= '0;
            r_repeating <= 1'b0;
         end else if (tick) begin
            if (rep) begin
               r_cnt       <= '0;
               r_repeating <= 1'b1;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end
      end
   end

endmodule

// File: rtl/alarm_clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_clock_mode_ctrl
// Set-mode sequencer for the digital alarm clock. Turns debounced buttons into
// mode changes and one-cycle increment/clear strobes for the time and alarm
// registers, plus freeze, target-select, blink and alarm-enable controls.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   tick_1hz, tick_fast  : one-cycle strobes (1 Hz idle timeout, 8 Hz repeat/blink)
//   btn_mode/inc/alarm   : debounced levels, high while pressed
//   mode                 : current state (mode_e encoding)
//   inc_hr, inc_min      : one-cycle increment strobes for the target register
//   tgt_alarm            : 1 = alarm register is the target/display
//   time_hold            : freeze timekeeping while the time is being set
//   clr_sec              : one-cycle strobe zeroing the seconds counter
//   blink                : blink phase of the edited field, 0 in RUN
//   alarm_en             : alarm armed
// All outputs are registered.
// -----------------------------------------------------------------------------
module alarm_clock_mode_ctrl
   import alarm_clock_pkg::*;
#(
   parameter int TIMEOUT_S     = TIMEOUT_S_DEF,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
   parameter int BLINK_DIV     = BLINK_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       tick_fast,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_alarm,
   output logic [2:0] mode,
   output logic       inc_hr,
   output logic       inc_min,
   output logic       tgt_alarm,
   output logic       time_hold,
   output logic       clr_sec,
   output logic       blink,
   output logic       alarm_en
);

   localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT_S);
   localparam logic [3:0] LP_BLINK   = 4'(BLINK_DIV);

   mode_e      r_mode;
   logic       r_mode_prev;
   logic       r_alarm_prev;
   logic       r_inc_hr;
   logic       r_inc_min;
   logic       r_clr_sec;
   logic       r_time_hold;
   logic       r_tgt_alarm;
   logic       r_blink;
   logic       r_alarm_en;
   logic [3:0] r_idle_cnt;
   logic [3:0] r_blink_cnt;

   logic       w_inc_press;
   logic       w_inc_rep;
   logic       w_mode_press;
   logic       w_alarm_press;
   logic       w_any_press;
   logic       w_in_set;
   logic       w_timeout;
   logic       w_inc_evt;
   logic       w_enter_set;
   logic       w_clr_sec;
   mode_e      w_mode_nxt;

   btn_edge_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_inc_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .level (btn_inc),
      .tick  (tick_fast),
      .press (w_inc_press),
      .rep   (w_inc_rep)
   );

   always_comb begin
      w_mode_press  = btn_mode  & ~r_mode_prev;
      w_alarm_press = btn_alarm & ~r_alarm_prev;
      w_any_press   = w_mode_press | w_alarm_press | w_inc_press;
      w_in_set      = is_set_state(r_mode);
      // A press in the same cycle restarts the idle count instead of expiring it.
      w_timeout     = w_in_set & tick_1hz & ~w_any_press &
                      ((r_idle_cnt + 4'd1) == LP_TIMEOUT);

      w_mode_nxt = r_mode;
      if (w_mode_press) begin
         w_mode_nxt = next_mode(r_mode);
      end else if (w_timeout) begin
         w_mode_nxt = MODE_RUN;
      end

      w_enter_set = is_set_state(w_mode_nxt) & (w_mode_nxt != r_mode);
      // A mode press in the same cycle swallows any increment.
      w_inc_evt   = w_in_set & ~w_mode_press & (w_inc_press | w_inc_rep);
      // Seconds restart when leaving time-set, except T_HR -> T_MIN.
      w_clr_sec   = (w_mode_press & (r_mode == MODE_SET_T_MIN)) |
                    (w_timeout & is_time_state(r_mode));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode       <= MODE_RUN;
         r_mode_prev  <= 1'b0;
         r_alarm_prev <= 1'b0;
         r_inc_hr     <= 1'b0;
         r_inc_min    <= 1'b0;
         r_clr_sec    <= 1'b0;
         r_time_hold  <= 1'b0;
         r_tgt_alarm  <= 1'b0;
         r_blink      <= 1'b0;
         r_alarm_en   <= 1'b0;
         r_idle_cnt   <= '0;
         r_blink_cnt  <= '0;
      end else begin
         r_mode_prev  <= btn_mode;
         r_alarm_prev <= btn_alarm;
         r_mode       <= w_mode_nxt;
         r_inc_hr     <= w_inc_evt & is_hr_state(r_mode);
         r_inc_min    <= w_inc_evt & is_min_state(r_mode);
         r_clr_sec    <= w_clr_sec;
         r_time_hold  <= is_time_state(w_mode_nxt);
         r_tgt_alarm  <= is_alarm_state(w_mode_nxt);

         if (w_alarm_press && !w_in_set) begin
            r_alarm_en <= ~r_alarm_en;
         end

         if (!is_set_state(w_mode_nxt) || w_enter_set || w_any_press) begin
            r_idle_cnt <= '0;
         end else if (tick_1hz) begin
            r_idle_cnt <= r_idle_cnt + 4'd1;
         end

         // Field is shown solid while the increment button is held.
         if (!is_set_state(w_mode_nxt)) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
         end else if (w_enter_set || btn_inc) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
         end else if (tick_fast) begin
            if ((r_blink_cnt + 4'd1) == LP_BLINK) begin
               r_blink     <= ~r_blink;
               r_blink_cnt <= '0;
            end else begin
               r_blink_cnt <= r_blink_cnt + 4'd1;
            end
         end
      end
   end

   assign mode      = r_mode;
   assign inc_hr    = r_inc_hr;
   assign inc_min   = r_inc_min;
   assign tgt_alarm = r_tgt_alarm;
   assign time_hold = r_time_hold;
   assign clr_sec   = r_clr_sec;
   assign blink     = r_blink;
   assign alarm_en  = r_alarm_en;

endmodule

// File: doc/alarm_clock_mode_ctrl.md
# alarm_clock_mode_ctrl

Mode/sequencing controller for the digital alarm clock. It turns the debounced front-panel buttons into a set-mode state machine and emits single-cycle increment/clear strobes to the timekeeping and alarm registers. It also drives freeze, target-select, blink and alarm-enable controls. It sits between the button synchronizer/debouncer and the time/alarm counter datapath inside `tt_um_digital_alarm_clock`.

## Interface
- `TIMEOUT_S`, 10: idle seconds in any set state before returning to RUN (1..15).
- `REPEAT_DELAY`, 4: `tick_fast` ticks `btn_inc` must be held before auto-repeat starts (1..15).
- `REPEAT_PERIOD`, 1: `tick_fast` ticks between auto-repeat pulses (1..15).
- `BLINK_DIV`, 2: `tick_fast` ticks per blink half-period (1..15).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_1hz` in 1: one-cycle strobe, 1 Hz.
- `tick_fast` in 1: one-cycle strobe, 8 Hz.
- `btn_mode` in 1: debounced, synchronized level, high while pressed.
- `btn_inc` in 1: same, increment button.
- `btn_alarm` in 1: same, alarm on/off button.
- `mode` out 3: current state encoding.
- `inc_hr` out 1: one-cycle strobe, increment the hours field of the target register.
- `inc_min` out 1: one-cycle strobe, increment the minutes field of the target register.
- `tgt_alarm` out 1: 1 = target/display is the alarm register, 0 = time register.
- `time_hold` out 1: freeze time counting.
- `clr_sec` out 1: one-cycle strobe, zero the seconds counter.
- `blink` out 1: blink phase for the field being edited; 0 outside set states.
- `alarm_en` out 1: alarm armed.

## Operation
- Press = rising edge of a button level: current 1, previous-cycle registered copy 0.
- States: RUN=0, SET_T_HR=1, SET_T_MIN=2, SET_A_HR=3, SET_A_MIN=4.
- `btn_mode` press cycles RUN→SET_T_HR→SET_T_MIN→SET_A_HR→SET_A_MIN→RUN.
- `btn_inc` press, and each auto-repeat:
  - SET_*_HR states: `inc_hr`.
  - SET_*_MIN states: `inc_min`.
  - RUN: ignored.
- Auto-repeat:
  - A hold counter clears on press.
  - It counts `tick_fast` while `btn_inc` stays high.
  - At `REPEAT_DELAY` it emits a pulse, then emits one pulse every `REPEAT_PERIOD` ticks.
  - Release clears it.
- `btn_alarm` press toggles `alarm_en` in RUN only; ignored in set states.
- Timeout:
  - The idle counter clears on entry to any set state and on any button press.
  - It counts `tick_1hz` in set states.
  - Reaching `TIMEOUT_S` forces RUN.
- `time_hold` = 1 in SET_T_HR and SET_T_MIN.
- `clr_sec` pulses on the transition from SET_T_MIN to SET_A_HR, and on any exit from SET_T_HR/SET_T_MIN via timeout.
- `tgt_alarm` = 1 in SET_A_HR and SET_A_MIN.
- `blink`:
  - Set to 1 on set-state entry.
  - Toggles every `BLINK_DIV` `tick_fast` ticks.
  - Forced to 1 while an inc pulse or auto-repeat is active, so the field stays visible while adjusting.
- Simultaneous events in one cycle:
  - Mode press beats inc press; the inc is dropped.
  - Mode press beats timeout.
  - `tick_1hz` and `tick_fast` in the same cycle are both counted.
- The datapath handles field wrap (23→0, 59→0); this block never sees values.

## Timing
- All outputs are registered.
- Reset values: `mode`=RUN(0); `inc_hr`, `inc_min`, `clr_sec`, `time_hold`, `tgt_alarm`, `blink`, `alarm_en` all 0; edge registers and counters all 0.
- Edge registers reset to 0. A button already held at reset release therefore registers as a press on the first cycle after release.
- Press sampled high at edge N → state/strobe visible after edge N+1 (1-cycle latency). Strobes last exactly one cycle.
- Auto-repeat: the first pulse appears 1 cycle after the `REPEAT_DELAY`-th `tick_fast` counted during the hold.
- Timeout: RUN is visible 1 cycle after the `TIMEOUT_S`-th `tick_1hz`. `clr_sec` pulses in that same cycle when the exit is from a SET_T state.
- Reset mid-operation returns to RUN at once; pending strobes are lost.

## Structure
- Shared package `alarm_clock_pkg`: mode enum (3-bit encoding above) and parameter defaults.
- Sub-module `btn_edge_repeat`:
  - Parameters: `REPEAT_DELAY`, `REPEAT_PERIOD`.
  - Ports: `clk`, `rst_n`, `level`, `tick`, `press`, `rep`.
  - Instantiated for `btn_inc`.
  - `btn_mode` and `btn_alarm` use plain edge detects.
- Top-level: FSM, idle counter, blink divider.

## Test plan
- Reset, then three `btn_mode` presses → `mode` steps 1,2,3; `time_hold` high in 1–2 only; `tgt_alarm` high at 3; one `clr_sec` on the 2→3 transition.
- In SET_T_MIN, hold `btn_inc` for 10 `tick_fast` (defaults) → 1 press pulse plus auto-repeat pulses at hold ticks 4..10 = 8 `inc_min` strobes, 0 `inc_hr`.
- Enter SET_A_HR, then no buttons for 10 `tick_1hz` → `mode`=0 one cycle after the 10th tick, no `clr_sec`. Repeat from SET_T_HR → `clr_sec` pulses once.
- `btn_mode` and `btn_inc` rise in the same cycle while in SET_T_HR → `mode`=2, no inc strobe.
- In RUN, press `btn_alarm` twice → `alarm_en` 1 then 0. In SET_T_HR, the same presses leave `alarm_en` unchanged.
- Assert `rst_n`=0 mid-auto-repeat in SET_A_MIN → all outputs 0 asynchronously; after release with `btn_inc` still high, one strobe-free cycle in RUN.
